// File: rtl/merlin_icache_dm.sv
// -----------------------------------------------------------------------------
// merlin_icache_dm
//   Direct-mapped instruction cache with one 32-bit word per line. It sits
//   between the prefetch unit (ireq*/irsp*) and the instruction memory bus
//   (mreq*/mrsp*). Hits respond one cycle after accept. Misses issue a
//   single-word memory read, write the word into the line, and forward it.
//   invalidate_i (fence.i) clears every line.
//
// Parameters
//   C_INDEX_X     log2 of the line count; index = addr[C_INDEX_X+1:2],
//                 tag = addr[31:C_INDEX_X+2]
//
// Ports
//   clk_i, resetn_i        clock, asynchronous active-low reset
//   clk_en_i               clock enable; all state holds while low
//   ireqready_o/valid_i    fetch request handshake
//   ireqhpl_i, ireqaddr_i  request privilege level and fetch address
//   irspready_i/valid_o    fetch response handshake
//   irsprerr_o, irspdata_o response error flag and instruction word
//   invalidate_i           pulse: invalidate all lines
//   mreqready_i/valid_o    memory request handshake
//   mreqhpl_o, mreqaddr_o  memory request privilege level and word address
//   mrspvalid_i, mrsperr_i, mrspdata_i   memory response
//   stat_hit_o, stat_miss_o              hit / miss counters
//
// Build option
//   MERLIN_ICACHE_STATS_EN  when defined, the hit/miss counters exist;
//                           otherwise both stat outputs are tied to zero.
// -----------------------------------------------------------------------------
module merlin_icache_dm #(
  parameter int unsigned C_INDEX_X = 6
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        clk_en_i,
  output logic        ireqready_o,
  input  logic        ireqvalid_i,
  input  logic [1:0]  ireqhpl_i,
  input  logic [31:0] ireqaddr_i,
  input  logic        irspready_i,
  output logic        irspvalid_o,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  input  logic        invalidate_i,
  input  logic        mreqready_i,
  output logic        mreqvalid_o,
  output logic [1:0]  mreqhpl_o,
  output logic [31:0] mreqaddr_o,
  input  logic        mrspvalid_i,
  input  logic        mrsperr_i,
  input  logic [31:0] mrspdata_i,
  output logic [31:0] stat_hit_o,
  output logic [31:0] stat_miss_o
);

  localparam int unsigned LINES   = 1 << C_INDEX_X;
  localparam int unsigned TAG_W   = 30 - C_INDEX_X;
  localparam int unsigned ENTRY_W = 1 + TAG_W + 32;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_MREQ,
    S_MRSP,
    S_FILL,
    S_FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [C_INDEX_X:0] walk_q, walk_d;
  logic [31:2]        addr_q, addr_d;
  logic [1:0]         hpl_q, hpl_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               flush_pend_q, flush_pend_d;
  logic               mreq_valid_q, mreq_valid_d;

  // Line storage and its single read/write port.
  logic [ENTRY_W-1:0]   ram [LINES];
  logic [ENTRY_W-1:0]   ram_rdata_q;
  logic                 ram_we, ram_re;
  logic [C_INDEX_X-1:0] ram_addr;
  logic [ENTRY_W-1:0]   ram_wdata;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             ireq_ready;
  logic             accept;
  logic             walk_last;
  logic             hit_evt, miss_evt;

  // Byte offset bits of the fetch address carry no information.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^ireqaddr_i[1:0];

  assign rd_valid  = ram_rdata_q[ENTRY_W-1];
  assign rd_tag    = ram_rdata_q[ENTRY_W-2 -: TAG_W];
  assign rd_data   = ram_rdata_q[31:0];
  assign hit       = rd_valid && (rd_tag == addr_q[31:C_INDEX_X+2]);
  assign walk_last = (walk_q == {1'b0, {C_INDEX_X{1'b1}}});

  // A hit that completes this cycle frees the cache for the next request,
  // unless an invalidate is queued: then the flush must run first.
  assign ireq_ready = (state_q == S_IDLE) ||
                      ((state_q == S_LOOKUP) && hit && irspready_i && !flush_pend_q);
  assign accept      = ireqvalid_i && ireq_ready;
  assign ireqready_o = ireq_ready;

  assign mreqvalid_o = mreq_valid_q;
  assign mreqhpl_o   = hpl_q;
  assign mreqaddr_o  = {addr_q, 2'b00};

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    walk_d       = walk_q;
    addr_d       = addr_q;
    hpl_d        = hpl_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    flush_pend_d = flush_pend_q;
    mreq_valid_d = mreq_valid_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = addr_q[C_INDEX_X+1:2];
    ram_wdata    = '0;
    irspvalid_o  = 1'b0;
    irsprerr_o   = 1'b0;
    irspdata_o   = rd_data;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;

    unique case (state_q)
      S_INIT, S_FLUSH: begin
        // Clear one line per cycle; invalidate_i is ignored here because
        // the walk already covers every line.
        ram_we   = 1'b1;
        ram_addr = walk_q[C_INDEX_X-1:0];
        if (walk_last) begin
          walk_d  = '0;
          state_d = S_IDLE;
        end else begin
          walk_d = walk_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (accept) begin
          addr_d   = ireqaddr_i[31:2];
          hpl_d    = ireqhpl_i;
          ram_re   = 1'b1;
          ram_addr = ireqaddr_i[C_INDEX_X+1:2];
          state_d  = S_LOOKUP;
          if (invalidate_i) flush_pend_d = 1'b1;
        end else if (invalidate_i) begin
          state_d = S_FLUSH;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          irspvalid_o = 1'b1;
          if (irspready_i) begin
            hit_evt = 1'b1;
            if (accept) begin
              addr_d   = ireqaddr_i[31:2];
              hpl_d    = ireqhpl_i;
              ram_re   = 1'b1;
              ram_addr = ireqaddr_i[C_INDEX_X+1:2];
              if (invalidate_i) flush_pend_d = 1'b1;
            end else if (flush_pend_q || invalidate_i) begin
              flush_pend_d = 1'b0;
              state_d      = S_FLUSH;
            end else begin
              state_d = S_IDLE;
            end
          end else if (invalidate_i) begin
            // Response still owed; flush once it has been taken.
            flush_pend_d = 1'b1;
          end
        end else begin
          miss_evt     = 1'b1;
          mreq_valid_d = 1'b1;
          state_d      = S_MREQ;
          if (invalidate_i) flush_pend_d = 1'b1;
        end
      end

      S_MREQ: begin
        if (invalidate_i) flush_pend_d = 1'b1;
        if (mreqready_i) begin
          mreq_valid_d = 1'b0;
          state_d      = S_MRSP;
        end
      end

      S_MRSP: begin
        if (invalidate_i) flush_pend_d = 1'b1;
        if (mrspvalid_i) begin
          rsp_data_d = mrspdata_i;
          rsp_err_d  = mrsperr_i;
          state_d    = S_FILL;
          // An errored word must never become a hit later.
          if (!mrsperr_i) begin
            ram_we    = 1'b1;
            ram_wdata = {1'b1, addr_q[31:C_INDEX_X+2], mrspdata_i};
          end
        end
      end

      S_FILL: begin
        irspvalid_o = 1'b1;
        irsprerr_o  = rsp_err_q;
        irspdata_o  = rsp_data_q;
        if (irspready_i) begin
          if (flush_pend_q || invalidate_i) begin
            flush_pend_d = 1'b0;
            state_d      = S_FLUSH;
          end else begin
            state_d = S_IDLE;
          end
        end else if (invalidate_i) begin
          flush_pend_d = 1'b1;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!resetn_i) begin
      state_q      <= S_INIT;
      walk_q       <= '0;
      addr_q       <= '0;
      hpl_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      mreq_valid_q <= 1'b0;
    end else if (clk_en_i) begin
      state_q      <= state_d;
      walk_q       <= walk_d;
      addr_q       <= addr_d;
      hpl_q        <= hpl_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      flush_pend_q <= flush_pend_d;
      mreq_valid_q <= mreq_valid_d;
    end
  end

  // NOTE: the line array and its read register have no reset; the INIT walk
  // clears the valid bits, and the read register is always loaded before use.
  always_ff @(posedge clk_i) begin
    if (clk_en_i) begin
      if (ram_we) begin
        ram[ram_addr] <= ram_wdata;
      end else if (ram_re) begin
        ram_rdata_q <= ram[ram_addr];
      end
    end
  end

`ifdef MERLIN_ICACHE_STATS_EN
  logic [31:0] stat_hit_q, stat_hit_d;
  logic [31:0] stat_miss_q, stat_miss_d;

  always_comb begin
    stat_hit_d  = stat_hit_q + 32'(hit_evt);
    stat_miss_d = stat_miss_q + 32'(miss_evt);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else if (clk_en_i) begin
      stat_hit_q  <= stat_hit_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_hit_o  = stat_hit_q;
  assign stat_miss_o = stat_miss_q;
`else
  logic unused_stat_evt;
  assign unused_stat_evt = hit_evt ^ miss_evt;
  assign stat_hit_o  = 32'b0;
  assign stat_miss_o = 32'b0;
`endif

endmodule

// File: tb/tb_merlin_icache_dm.sv
// -----------------------------------------------------------------------------
// tb_merlin_icache_dm
//   Directed bench for merlin_icache_dm (C_INDEX_X = 6, 64 lines). Inputs are
//   driven and outputs sampled on the falling clock edge. The memory side is
//   driven by hand inside the fetch task so every handshake is exact.
// -----------------------------------------------------------------------------
module tb_merlin_icache_dm;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        clk_en_i;
  logic        ireqready_o;
  logic        ireqvalid_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspready_i;
  logic        irspvalid_o;
  logic        irsprerr_o;
  logic [31:0] irspdata_o;
  logic        invalidate_i;
  logic        mreqready_i;
  logic        mreqvalid_o;
  logic [1:0]  mreqhpl_o;
  logic [31:0] mreqaddr_o;
  logic        mrspvalid_i;
  logic        mrsperr_i;
  logic [31:0] mrspdata_i;
  logic [31:0] stat_hit_o;
  logic [31:0] stat_miss_o;

  int n_checks = 0;
  int n_errors = 0;

  merlin_icache_dm #(.C_INDEX_X(6)) dut (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .clk_en_i     (clk_en_i),
    .ireqready_o  (ireqready_o),
    .ireqvalid_i  (ireqvalid_i),
    .ireqhpl_i    (ireqhpl_i),
    .ireqaddr_i   (ireqaddr_i),
    .irspready_i  (irspready_i),
    .irspvalid_o  (irspvalid_o),
    .irsprerr_o   (irsprerr_o),
    .irspdata_o   (irspdata_o),
    .invalidate_i (invalidate_i),
    .mreqready_i  (mreqready_i),
    .mreqvalid_o  (mreqvalid_o),
    .mreqhpl_o    (mreqhpl_o),
    .mreqaddr_o   (mreqaddr_o),
    .mrspvalid_i  (mrspvalid_i),
    .mrsperr_i    (mrsperr_i),
    .mrspdata_i   (mrspdata_i),
    .stat_hit_o   (stat_hit_o),
    .stat_miss_o  (stat_miss_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge where the cache is ready, bounded.
  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ireqready_o && n < 200);
    if (!ireqready_o) check("ready_timeout", 32'(n), 32'd0);
  endtask

  // One fetch with irspready_i high. For a miss the memory request is held
  // one extra cycle before mreqready_i, then answered with word/err.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit,
                       input logic [31:0] word, input bit err, input bit inv_mrsp);
    wait_ready();
    ireqvalid_i = 1'b1;
    ireqaddr_i  = addr;
    ireqhpl_i   = 2'b10;
    @(negedge clk_i);
    ireqvalid_i = 1'b0;
    if (exp_hit) begin
      check("hit_valid", irspvalid_o, 1);
      check("hit_data", irspdata_o, word);
      check("hit_err", irsprerr_o, 0);
      check("hit_no_mreq", mreqvalid_o, 0);
    end else begin
      check("miss_no_rsp", irspvalid_o, 0);
      @(negedge clk_i);
      check("mreq_valid", mreqvalid_o, 1);
      check("mreq_addr", mreqaddr_o, {addr[31:2], 2'b00});
      check("mreq_hpl", mreqhpl_o, 2'b10);
      @(negedge clk_i);
      check("mreq_hold_valid", mreqvalid_o, 1);
      check("mreq_hold_addr", mreqaddr_o, {addr[31:2], 2'b00});
      mreqready_i = 1'b1;
      @(negedge clk_i);
      mreqready_i = 1'b0;
      check("mrsp_no_mreq", mreqvalid_o, 0);
      check("mrsp_no_rsp", irspvalid_o, 0);
      mrspvalid_i  = 1'b1;
      mrspdata_i   = word;
      mrsperr_i    = err;
      invalidate_i = inv_mrsp;
      @(negedge clk_i);
      mrspvalid_i  = 1'b0;
      mrsperr_i    = 1'b0;
      invalidate_i = 1'b0;
      check("fill_valid", irspvalid_o, 1);
      check("fill_data", irspdata_o, word);
      check("fill_err", irsprerr_o, 32'(err));
      check("fill_not_ready", ireqready_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_word [3];
    b2b_addr[0] = 32'h100; b2b_word[0] = 32'h0000_0013;
    b2b_addr[1] = 32'h104; b2b_word[1] = 32'h0010_0113;
    b2b_addr[2] = 32'h108; b2b_word[2] = 32'h0020_0193;

    resetn_i     = 1'b0;
    clk_en_i     = 1'b1;
    ireqvalid_i  = 1'b0;
    ireqhpl_i    = 2'b00;
    ireqaddr_i   = '0;
    irspready_i  = 1'b1;
    invalidate_i = 1'b0;
    mreqready_i  = 1'b0;
    mrspvalid_i  = 1'b0;
    mrsperr_i    = 1'b0;
    mrspdata_i   = '0;

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_ireqready", ireqready_o, 0);
    check("rst_irspvalid", irspvalid_o, 0);
    check("rst_mreqvalid", mreqvalid_o, 0);
    check("rst_stat_hit", stat_hit_o, 0);
    check("rst_stat_miss", stat_miss_o, 0);

    // INIT walk: ready stays low for 64 cycles, no memory traffic.
    resetn_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (mreqvalid_o !== 1'b0) check("init_mreqvalid", mreqvalid_o, 0);
    end while (!ireqready_o && n < 200);
    check("init_len", 32'(n), 32'd64);

    // Cold miss then hit.
    fetch(32'h100, 0, 32'h0000_0013, 0, 0);
    fetch(32'h100, 1, 32'h0000_0013, 0, 0);

    // Errored fill is delivered but not cached; 0x200 shares index 0.
    fetch(32'h200, 0, 32'hDEAD_BEEF, 1, 0);
    fetch(32'h200, 0, 32'h0000_0073, 0, 0);

    // Conflict on index 0: 0x100 was evicted, 0x4100 evicts it again.
    fetch(32'h100,  0, 32'h0000_0013, 0, 0);
    fetch(32'h4100, 0, 32'h0040_0093, 0, 0);
    fetch(32'h100,  0, 32'h0000_0013, 0, 0);

    // Back-to-back hits with ireqvalid_i held: one response per cycle.
    fetch(32'h104, 0, 32'h0010_0113, 0, 0);
    fetch(32'h108, 0, 32'h0020_0193, 0, 0);
    wait_ready();
    ireqvalid_i = 1'b1;
    ireqaddr_i  = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("b2b_valid", irspvalid_o, 1);
      check("b2b_data", irspdata_o, b2b_word[i]);
      check("b2b_no_mreq", mreqvalid_o, 0);
      check("b2b_ready", ireqready_o, 1);
      if (i < 2) ireqaddr_i = b2b_addr[i+1];
    end
    ireqvalid_i = 1'b0;

    // Hit response held while irspready_i is low.
    wait_ready();
    irspready_i = 1'b0;
    ireqvalid_i = 1'b1;
    ireqaddr_i  = 32'h104;
    @(negedge clk_i);
    ireqvalid_i = 1'b0;
    check("hold_valid", irspvalid_o, 1);
    check("hold_ready", ireqready_o, 0);
    @(negedge clk_i);
    check("hold_valid2", irspvalid_o, 1);
    check("hold_data2", irspdata_o, 32'h0010_0113);
    irspready_i = 1'b1;
    @(negedge clk_i);
    check("hold_done", irspvalid_o, 0);

    // Invalidate while waiting for memory: fill still delivered, then the
    // handshake edge plus a 64-cycle flush before ready returns.
    fetch(32'h30C, 0, 32'h0030_0213, 0, 1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ireqready_o && n < 200);
    check("flush_len", 32'(n), 32'd65);
    fetch(32'h100, 0, 32'h0000_0013, 0, 0);
    fetch(32'h100, 1, 32'h0000_0013, 0, 0);

    // Invalidate while idle: same flush length, 0x104 no longer hits.
    wait_ready();
    invalidate_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      invalidate_i = 1'b0;
      n++;
    end while (!ireqready_o && n < 200);
    check("idle_flush_len", 32'(n), 32'd65);
    fetch(32'h104, 0, 32'h0010_0113, 0, 0);

    @(negedge clk_i);
`ifdef MERLIN_ICACHE_STATS_EN
    check("stat_hit", stat_hit_o, 32'd6);
    check("stat_miss", stat_miss_o, 32'd11);
`else
    check("stat_hit", stat_hit_o, 32'd0);
    check("stat_miss", stat_miss_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
